uart_rx_fifo: RTL and testbench

Receive-side buffer directly downstream of the UART RX controller FSM. Captures each completed frame's parallel byte when the FSM's data_valid rises. Stores frames in a small synchronous first-word-fall-through FIFO. Presents them to the system on a valid/ready stream, with full/empty/level status and a sticky overflow flag.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_fifo_if.sv | 22 ++
 rtl/uart_rise_det.sv | 18 +
 rtl/uart_rx_fifo.sv | 106 ++++++++++
 tb/tb_uart_rx_fifo.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants and error-counter helper for the UART receive buffer
package uart_rx_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ERR_CNT_W      = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   // Clear takes priority, but an edge in the clearing cycle still counts once.
   function automatic logic [ERR_CNT_W-1:0] err_cnt_next(
      input logic [ERR_CNT_W-1:0] cnt,
      input logic                 rise,
      input logic                 clr
   );
      if (clr)
         return {{(ERR_CNT_W-1){1'b0}}, rise};
      else if (rise && (cnt != ERR_CNT_MAX))
         return cnt + 1'b1;
      else
         return cnt;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - RX FSM capture inputs and FWFT output stream of the receive buffer
interface uart_rx_fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_err;
   logic                  stop_err;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output p_data, data_valid, par_err, stop_err, out_ready,
      input  out_data, out_valid
   );

   modport slave (
      input  p_data, data_valid, par_err, stop_err, out_ready,
      output out_data, out_valid
   );
endinterface

// File: rtl/uart_rise_det.sv
// rtl/uart_rise_det.sv - registered rising-edge detector, one-cycle pulse per low-to-high transition
module uart_rise_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);
   logic din_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         din_q <= 1'b0;
      else
         din_q <= din;
   end

   assign pulse = din & ~din_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART RX frame capture into a FWFT FIFO with status and sticky overflow
// Define UART_RX_ERR_CNT_EN to build the parity/stop-error edge counters.
module uart_rx_fifo
   import uart_rx_pkg::*;
#(
   parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter  int DEPTH      = 8,
   localparam int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_rx_fifo_if.slave        bus,
   output logic                 fifo_full,
   output logic                 fifo_empty,
   output logic [CNT_W-1:0]     level,
   output logic                 overflow,
   input  logic                 clr_ovf,
   output logic [ERR_CNT_W-1:0] par_err_cnt,
   output logic [ERR_CNT_W-1:0] stop_err_cnt
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  wr;
   logic                  rd;
   logic                  wr_ok;

   uart_rise_det u_dv_rise (
      .clk   (clk),
      .rst   (rst),
      .din   (bus.data_valid),
      .pulse (wr)
   );

   // MSB of each pointer is the wrap bit distinguishing full from empty.
   assign fifo_empty    = (wr_ptr == rd_ptr);
   assign fifo_full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign level         = wr_ptr - rd_ptr;
   assign bus.out_valid = ~fifo_empty;
   assign bus.out_data  = mem[rd_ptr[AW-1:0]];
   assign rd            = bus.out_valid & bus.out_ready;
   assign wr_ok         = wr & (~fifo_full | rd);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd)
            rd_ptr <= rd_ptr + 1'b1;
         if (wr && !wr_ok)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (wr_ok) begin
         mem[wr_ptr[AW-1:0]] <= bus.p_data;
      end
   end

`ifdef UART_RX_ERR_CNT_EN
   logic par_rise;
   logic stop_rise;

   uart_rise_det u_par_rise (
      .clk   (clk),
      .rst   (rst),
      .din   (bus.par_err),
      .pulse (par_rise)
   );

   uart_rise_det u_stop_rise (
      .clk   (clk),
      .rst   (rst),
      .din   (bus.stop_err),
      .pulse (stop_rise)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_err_cnt  <= '0;
         stop_err_cnt <= '0;
      end else begin
         par_err_cnt  <= err_cnt_next(par_err_cnt, par_rise, clr_ovf);
         stop_err_cnt <= err_cnt_next(stop_err_cnt, stop_rise, clr_ovf);
      end
   end
`else
   logic unused_err;
   assign unused_err   = bus.par_err ^ bus.stop_err;
   assign par_err_cnt  = '0;
   assign stop_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for the UART receive FIFO
module tb_uart_rx_fifo;
   import uart_rx_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fifo_full;
   logic       fifo_empty;
   logic [3:0] level;
   logic       overflow;
   logic       clr_ovf = 1'b0;
   logic [7:0] par_err_cnt;
   logic [7:0] stop_err_cnt;

   int errors = 0;
   int checks = 0;
   logic [7:0] sb [$];
   logic [7:0] exp_d;

   uart_rx_fifo_if #(.DATA_WIDTH(8)) bus ();

   uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .level        (level),
      .overflow     (overflow),
      .clr_ovf      (clr_ovf),
      .par_err_cnt  (par_err_cnt),
      .stop_err_cnt (stop_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One frame: a single-cycle data_valid high followed by a low cycle.
   task automatic send(input logic [7:0] d);
      bus.p_data     = d;
      bus.data_valid = 1'b1;
      tick();
      bus.data_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", fifo_full); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
      checks++; if (par_err_cnt !== 8'd0 || stop_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d/%0d want 0/0", par_err_cnt, stop_err_cnt); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_hold();
      bus.p_data     = 8'hA5;
      bus.data_valid = 1'b1;
      sb.push_back(8'hA5);
      tick();
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL hold_level_first: got %0d want 1", level); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL hold_out_data: got %h want a5", bus.out_data); end
      for (int i = 0; i < 4; i++) tick();
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL hold_single_write: got %0d want 1", level); end
      bus.data_valid = 1'b0;
      tick();
      bus.out_ready = 1'b1;
      for (int n = 0; n < 20 && bus.out_valid; n++) begin
         exp_d = sb.pop_front();
         checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL hold_drain: got %h want %h", bus.out_data, exp_d); end
         tick();
      end
      bus.out_ready = 1'b0;
      checks++; if (fifo_empty !== 1'b1 || sb.size() != 0) begin errors++; $display("FAIL hold_empty: got empty=%b left=%0d want 1/0", fifo_empty, sb.size()); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 8; i++) begin
         send(8'(i));
         sb.push_back(8'(i));
      end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", fifo_full); end
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level8: got %0d want 8", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
      send(8'h09);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level_hold: got %0d want 8", level); end
      // Fresh overflow coinciding with clear: set must win.
      bus.p_data     = 8'h0A;
      bus.data_valid = 1'b1;
      clr_ovf        = 1'b1;
      tick();
      bus.data_valid = 1'b0;
      clr_ovf        = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
      tick();
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
      bus.out_ready = 1'b1;
      for (int n = 0; n < 20 && bus.out_valid; n++) begin
         exp_d = sb.pop_front();
         checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL ovf_drain: got %h want %h", bus.out_data, exp_d); end
         tick();
      end
      bus.out_ready = 1'b0;
      checks++; if (fifo_empty !== 1'b1 || sb.size() != 0) begin errors++; $display("FAIL ovf_drain_end: got empty=%b left=%0d want 1/0", fifo_empty, sb.size()); end
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 8; i++) begin
         send(8'h10 + 8'(i));
         sb.push_back(8'h10 + 8'(i));
      end
      bus.p_data     = 8'h55;
      bus.data_valid = 1'b1;
      bus.out_ready  = 1'b1;
      exp_d = sb.pop_front();
      checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL full_rw_head: got %h want %h", bus.out_data, exp_d); end
      sb.push_back(8'h55);
      tick();
      bus.data_valid = 1'b0;
      bus.out_ready  = 1'b0;
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_rw_level: got %0d want 8", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_rw_overflow: got %b want 0", overflow); end
      tick();
      bus.out_ready = 1'b1;
      for (int n = 0; n < 20 && bus.out_valid; n++) begin
         exp_d = sb.pop_front();
         checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL full_rw_drain: got %h want %h", bus.out_data, exp_d); end
         tick();
      end
      bus.out_ready = 1'b0;
      checks++; if (fifo_empty !== 1'b1 || sb.size() != 0) begin errors++; $display("FAIL full_rw_end: got empty=%b left=%0d want 1/0", fifo_empty, sb.size()); end
   endtask

   task automatic test_empty_rw();
      bus.p_data     = 8'h3C;
      bus.data_valid = 1'b1;
      bus.out_ready  = 1'b1;
      tick();
      bus.data_valid = 1'b0;
      bus.out_ready  = 1'b0;
      checks++; if (level !== 4'd1 || bus.out_data !== 8'h3C) begin errors++; $display("FAIL empty_rw: got level=%0d data=%h want 1/3c", level, bus.out_data); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL empty_rw_drain: got %b want 1", fifo_empty); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++) begin
         bus.p_data     = 8'h30 + 8'(i);
         bus.data_valid = 1'b1;
         sb.push_back(8'h30 + 8'(i));
         tick();
         bus.data_valid = 1'b0;
         exp_d = sb.pop_front();
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin errors++; $display("FAIL b2b_word%0d: got v=%b d=%h want 1/%h", i, bus.out_valid, bus.out_data, exp_d); end
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
      end
      checks++; if (fifo_empty !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL b2b_end: got empty=%b level=%0d want 1/0", fifo_empty, level); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 8; i++) begin
         send(8'hC0 + 8'(i));
         sb.push_back(8'hC0 + 8'(i));
      end
      send(8'hEE);
      bus.out_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         exp_d = sb.pop_front();
         checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL rmid_drain: got %h want %h", bus.out_data, exp_d); end
         tick();
      end
      bus.out_ready = 1'b0;
      checks++; if (level !== 4'd3 || overflow !== 1'b1) begin errors++; $display("FAIL rmid_pre: got level=%0d ovf=%b want 3/1", level, overflow); end
      rst = 1'b0;
      #1;
      checks++; if (level !== 4'd0 || bus.out_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rmid_async: got level=%0d v=%b ovf=%b want 0/0/0", level, bus.out_valid, overflow); end
      sb.delete();
      tick();
      rst = 1'b1;
      tick();
      send(8'h77);
      sb.push_back(8'h77);
      checks++; if (level !== 4'd1 || bus.out_data !== 8'h77) begin errors++; $display("FAIL rmid_after: got level=%0d data=%h want 1/77", level, bus.out_data); end
      exp_d = sb.pop_front();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b want 1 (last %h)", fifo_empty, exp_d); end
   endtask

   task automatic test_err_cnt();
      for (int i = 0; i < 3; i++) begin
         bus.par_err = 1'b1; tick();
         bus.par_err = 1'b0; tick();
      end
      for (int i = 0; i < 300; i++) begin
         bus.stop_err = 1'b1; tick();
         bus.stop_err = 1'b0; tick();
      end
`ifdef UART_RX_ERR_CNT_EN
      checks++; if (par_err_cnt !== 8'd3) begin errors++; $display("FAIL par_cnt: got %0d want 3", par_err_cnt); end
      checks++; if (stop_err_cnt !== 8'd255) begin errors++; $display("FAIL stop_cnt_sat: got %0d want 255", stop_err_cnt); end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checks++; if (par_err_cnt !== 8'd0 || stop_err_cnt !== 8'd0) begin errors++; $display("FAIL cnt_clear: got %0d/%0d want 0/0", par_err_cnt, stop_err_cnt); end
      clr_ovf     = 1'b1;
      bus.par_err = 1'b1;
      tick();
      clr_ovf     = 1'b0;
      bus.par_err = 1'b0;
      checks++; if (par_err_cnt !== 8'd1) begin errors++; $display("FAIL cnt_clr_edge: got %0d want 1", par_err_cnt); end
`else
      checks++; if (par_err_cnt !== 8'd0 || stop_err_cnt !== 8'd0) begin errors++; $display("FAIL cnt_disabled: got %0d/%0d want 0/0", par_err_cnt, stop_err_cnt); end
`endif
   endtask

   initial begin
      bus.p_data     = 8'h00;
      bus.data_valid = 1'b0;
      bus.par_err    = 1'b0;
      bus.stop_err   = 1'b0;
      bus.out_ready  = 1'b0;
      test_reset();
      test_hold();
      test_overflow();
      test_full_rw();
      test_empty_rw();
      test_back_to_back();
      test_reset_mid();
      test_err_cnt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
